// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and sizes for the 4x4 keypad scanner.
//                Optional feature macro used by this block: KEYPAD_AUTOREPEAT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    // Classification of one complete scan frame
    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_t;

endpackage

`default_nettype wire

// File: rtl/keypad_scan_if.sv
// ============================================================================
//  Module      : keypad_scan_if
//  Description : Keypad pin and key-event bundle. The scanner is the master:
//                it reads rows and drives columns and the key event outputs.
//                Optional feature macro used by this block: KEYPAD_AUTOREPEAT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scan_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;        // active-low rows from the pins
    logic [NUM_COLS-1:0] col;        // active-low one-hot column drive
    logic [3:0]          key;        // last accepted code
    logic                key_valid;  // one-cycle strobe
    logic                key_held;   // accepted key currently down

    modport master (
        input  row,
        output col,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ============================================================================
//  Module      : keypad_debounce
//  Description : Frame-level press/release debouncer. Consumes one result per
//                scan frame and produces key, key_valid and key_held.
//                KEYPAD_AUTOREPEAT_EN adds a periodic repeat strobe while held.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE      = 3,
    parameter int REPEAT_FRAMES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_stb,
    input  frame_res_t frame_res,
    input  logic [3:0] frame_code,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    if (DEBOUNCE < 1 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_debounce: DEBOUNCE and REPEAT_FRAMES must be >= 1");
    end

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;       // matching press frames seen
    logic [CW-1:0]   rcnt, rcnt_nx;     // consecutive empty frames while held
    logic [3:0]      cand, cand_nx;     // code being debounced
    logic [3:0]      key_nx;
    logic            valid_nx;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0]   rep, rep_nx;       // consecutive held frames since last strobe
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            cand      <= '0;
            key       <= '0;
            key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep       <= '0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rcnt      <= rcnt_nx;
            cand      <= cand_nx;
            key       <= key_nx;
            key_valid <= valid_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep       <= rep_nx;
`endif
        end
    end

    // Next-state logic, evaluated only on the frame strobe
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rcnt_nx  = rcnt;
        cand_nx  = cand;
        key_nx   = key;
        valid_nx = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nx   = rep;
`endif
        if (frame_stb) begin
            case (state)
                ST_IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        cand_nx = frame_code;
                        if (DEBOUNCE == 1) begin
                            state_nx = ST_PRESSED;
                            key_nx   = frame_code;
                            valid_nx = 1'b1;
                            cnt_nx   = '0;
                            rcnt_nx  = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_nx   = '0;
`endif
                        end else begin
                            state_nx = ST_DEBOUNCE;
                            cnt_nx   = CW'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_res == RES_SINGLE && frame_code == cand) begin
                        if (cnt + CW'(1) == CW'(DEBOUNCE)) begin
                            state_nx = ST_PRESSED;
                            key_nx   = cand;
                            valid_nx = 1'b1;
                            cnt_nx   = '0;
                            rcnt_nx  = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_nx   = '0;
`endif
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end else begin
                        // Any break in the run discards the candidate
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_res == RES_NONE) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_nx = '0;
`endif
                        if (rcnt + CW'(1) == CW'(DEBOUNCE)) begin
                            state_nx = ST_IDLE;
                            rcnt_nx  = '0;
                        end else begin
                            rcnt_nx = rcnt + CW'(1);
                        end
                    end else begin
                        // Still held (or other keys added): release run restarts
                        rcnt_nx = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep + RW'(1) == RW'(REPEAT_FRAMES)) begin
                            valid_nx = 1'b1;
                            rep_nx   = '0;
                        end else begin
                            rep_nx = rep + RW'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    rcnt_nx  = '0;
                end
            endcase
        end
    end

    assign key_held = (state == ST_PRESSED);

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 matrix keypad scanner. Synchronizes rows, cycles an
//                active-low column drive, classifies each 4-slot frame and
//                hands the result to the frame debouncer.
//                Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int DEBOUNCE      = 3,
    parameter int REPEAT_FRAMES = 25
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4) begin : g_param_check
        $error("keypad_scan: SCAN_DIV must be >= 4");
    end

    logic [NUM_ROWS-1:0] sync1, sync2;
    logic [DIV_W-1:0]    div;
    logic [1:0]          col_idx;
    logic [NUM_COLS-1:0] col_drv;
    logic [1:0]          acc_cnt;      // low bits seen this frame, saturating at 2
    logic [3:0]          acc_code;     // code of the first low bit this frame

    logic                tick;
    logic [1:0]          slot_cnt;
    logic [3:0]          slot_code;
    logic [2:0]          sum_cnt;
    logic [1:0]          tot_cnt;
    logic [3:0]          tot_code;
    logic                frame_stb;
    frame_res_t          frame_res;

    assign tick = (div == DIV_W'(SCAN_DIV - 1));

    // Classify the current slot sample and merge it with the frame so far
    always_comb begin
        slot_cnt  = '0;
        slot_code = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!sync2[r]) begin
                if (slot_cnt != 2'd2) slot_cnt = slot_cnt + 2'd1;
                slot_code = {2'(r), col_idx};
            end
        end
        sum_cnt  = {1'b0, acc_cnt} + {1'b0, slot_cnt};
        tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code = (acc_cnt != 2'd0) ? acc_code : slot_code;
    end

    // The column-3 tick closes the frame, including that tick's own sample
    assign frame_stb = tick && (col_idx == 2'd3);
    assign frame_res = (tot_cnt == 2'd0) ? RES_NONE :
                       (tot_cnt == 2'd1) ? RES_SINGLE : RES_MULTI;

    // Synchronizer, slot divider, column driver and frame accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '1;
            sync2    <= '1;
            div      <= '0;
            col_idx  <= '0;
            col_drv  <= 4'b1110;
            acc_cnt  <= '0;
            acc_code <= '0;
        end else begin
            sync1 <= kp.row;
            sync2 <= sync1;
            if (tick) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                col_drv <= ~(4'b0001 << (col_idx + 2'd1));
                if (col_idx == 2'd3) begin
                    acc_cnt  <= '0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= tot_cnt;
                    acc_code <= tot_code;
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    assign kp.col = col_drv;

    keypad_debounce #(
        .DEBOUNCE      (DEBOUNCE),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_stb  (frame_stb),
        .frame_res  (frame_res),
        .frame_code (tot_code),
        .key        (kp.key),
        .key_valid  (kp.key_valid),
        .key_held   (kp.key_held)
    );

endmodule

`default_nettype wire
